// File: rtl/lighthouse_sample_arbiter.sv
// Merges per-sensor lighthouse samples into one valid/ready record stream via one-entry slots and round-robin drain.
// Latency: strobe edge t -> slot valid -> out_valid after edge t+1; one record per cycle sustained.
// Backpressure: out_record/out_valid hold while !out_ready; a strobe hitting its own full, undrained slot is dropped and counted.
module lighthouse_sample_arbiter #(
    parameter int NUM_SENSORS = 4,
    parameter int ANGLE_BITS  = 16,
    parameter int OVF_BITS    = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_SENSORS-1:0]            strobe,
    input  logic [NUM_SENSORS*ANGLE_BITS-1:0] angle,
    input  logic [NUM_SENSORS-1:0]            axis,
    input  logic [NUM_SENSORS-1:0]            data,
    input  logic [NUM_SENSORS-1:0]            lighthouse,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [ANGLE_BITS+11:0]            out_record,
    output logic [NUM_SENSORS-1:0]            overflow,
    output logic [OVF_BITS-1:0]               drop_count,
    input  logic                              clear_ovf
);

    localparam int CW = OVF_BITS + 5;

    logic [NUM_SENSORS-1:0] slot_vld;
    logic [NUM_SENSORS-1:0] slot_axis;
    logic [NUM_SENSORS-1:0] slot_data;
    logic [NUM_SENSORS-1:0] slot_lh;
    logic [ANGLE_BITS-1:0]  slot_angle [NUM_SENSORS];

    logic [3:0]             rr_last;
    logic [3:0]             grant;
    logic                   found;
    logic                   load_en;
    logic [NUM_SENSORS-1:0] drain;
    logic [NUM_SENSORS-1:0] capture;
    logic [NUM_SENSORS-1:0] drop;
    logic [4:0]             drop_num;
    logic [CW-1:0]          count_sum;
    logic [OVF_BITS-1:0]    count_nxt;
    logic                   sel_axis;
    logic                   sel_data;
    logic                   sel_lh;
    logic [ANGLE_BITS-1:0]  sel_angle;

    always_comb begin
        grant     = '0;
        found     = 1'b0;
        sel_axis  = 1'b0;
        sel_data  = 1'b0;
        sel_lh    = 1'b0;
        sel_angle = '0;
        drain     = '0;
        drop_num  = '0;
        // Two passes give the rotating order rr_last+1 .. N-1, then 0 .. rr_last.
        for (int j = 0; j < NUM_SENSORS; j++) begin
            if (!found && slot_vld[j] && (4'(j) > rr_last)) begin
                grant = 4'(j);
                found = 1'b1;
            end
        end
        for (int j = 0; j < NUM_SENSORS; j++) begin
            if (!found && slot_vld[j]) begin
                grant = 4'(j);
                found = 1'b1;
            end
        end
        load_en = (!out_valid || out_ready) && found;
        for (int j = 0; j < NUM_SENSORS; j++) begin
            if (grant == 4'(j)) begin
                sel_axis  = slot_axis[j];
                sel_data  = slot_data[j];
                sel_lh    = slot_lh[j];
                sel_angle = slot_angle[j];
            end
            drain[j] = load_en && (grant == 4'(j));
        end
        // A slot being drained this cycle can accept a new strobe.
        capture = strobe & (~slot_vld | drain);
        drop    = strobe & slot_vld & ~drain;
        for (int j = 0; j < NUM_SENSORS; j++) begin
            drop_num = drop_num + 5'(drop[j]);
        end
        count_sum = (clear_ovf ? '0 : CW'(drop_count)) + CW'(drop_num);
        count_nxt = (count_sum > CW'({OVF_BITS{1'b1}})) ? '1 : count_sum[OVF_BITS-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_vld  <= '0;
            slot_axis <= '0;
            slot_data <= '0;
            slot_lh   <= '0;
            for (int j = 0; j < NUM_SENSORS; j++) begin
                slot_angle[j] <= '0;
            end
        end else begin
            for (int j = 0; j < NUM_SENSORS; j++) begin
                if (capture[j]) begin
                    slot_vld[j]   <= 1'b1;
                    slot_axis[j]  <= axis[j];
                    slot_data[j]  <= data[j];
                    slot_lh[j]    <= lighthouse[j];
                    slot_angle[j] <= angle[j*ANGLE_BITS +: ANGLE_BITS];
                end else if (drain[j]) begin
                    slot_vld[j] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid  <= 1'b0;
            out_record <= '0;
            rr_last    <= 4'(NUM_SENSORS - 1);
        end else if (load_en) begin
            out_valid  <= 1'b1;
            out_record <= {4'hA + grant, 2'b00, sel_lh, sel_axis, 3'b000, sel_data, sel_angle};
            rr_last    <= grant;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // A drop in the clearing cycle survives the clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow   <= '0;
            drop_count <= '0;
        end else begin
            overflow   <= (clear_ovf ? '0 : overflow) | drop;
            drop_count <= count_nxt;
        end
    end

endmodule

// File: tb/tb_lighthouse_sample_arbiter.sv
// Bench for lighthouse_sample_arbiter: vector table plus record scoreboard, with a second
// 8-sensor / 2-bit-counter instance for id wrap and drop-count saturation.
module tb_lighthouse_sample_arbiter;

    localparam int N  = 4;
    localparam int SN = 8;
    localparam int AB = 16;
    localparam int RW = AB + 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic [N-1:0]    strobe, axis, data, lighthouse, overflow;
    logic [N*AB-1:0] angle;
    logic            out_valid, out_ready, clear_ovf;
    logic [RW-1:0]   out_record;
    logic [7:0]      drop_count;

    logic [SN-1:0]    s_strobe, s_axis, s_data, s_lh, s_overflow;
    logic [SN*AB-1:0] s_angle;
    logic             s_valid, s_ready, s_clear;
    logic [RW-1:0]    s_record;
    logic [1:0]       s_drop;

    lighthouse_sample_arbiter #(.NUM_SENSORS(N), .ANGLE_BITS(AB), .OVF_BITS(8)) dut (
        .clk(clk), .reset(reset), .strobe(strobe), .angle(angle), .axis(axis), .data(data),
        .lighthouse(lighthouse), .out_valid(out_valid), .out_ready(out_ready),
        .out_record(out_record), .overflow(overflow), .drop_count(drop_count), .clear_ovf(clear_ovf)
    );

    lighthouse_sample_arbiter #(.NUM_SENSORS(SN), .ANGLE_BITS(AB), .OVF_BITS(2)) dut_s (
        .clk(clk), .reset(reset), .strobe(s_strobe), .angle(s_angle), .axis(s_axis), .data(s_data),
        .lighthouse(s_lh), .out_valid(s_valid), .out_ready(s_ready),
        .out_record(s_record), .overflow(s_overflow), .drop_count(s_drop), .clear_ovf(s_clear)
    );

    int tests = 0;
    int fails = 0;
    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] exp_rec;

    typedef struct {
        int          sens;
        logic [15:0] ang;
        logic        ax;
        logic        dt;
        logic        lh;
        logic [RW-1:0] rec;
    } vec_t;
    vec_t tbl[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    // Records are compared in delivery order against what each test pushed.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_record: actual=%h required=none", out_record);
            end else begin
                exp_rec = exp_q.pop_front();
                check("scoreboard_record", 32'(out_record), 32'(exp_rec));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        strobe = '0; angle = '0; axis = '0; data = '0; lighthouse = '0; clear_ovf = 1'b0;
        s_strobe = '0; s_angle = '0; s_axis = '0; s_data = '0; s_lh = '0; s_clear = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        tick();
    endtask

    task automatic set_sensor(input int i, input logic [15:0] ang, input logic ax,
                              input logic dt, input logic lh);
        strobe[i]           = 1'b1;
        angle[i*AB +: AB]   = ang;
        axis[i]             = ax;
        data[i]             = dt;
        lighthouse[i]       = lh;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (3) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // {sensor, angle, axis, data, lighthouse, record}
        tbl[0] = '{2, 16'h1234, 1'b1, 1'b0, 1'b1, 28'hC301234};
        tbl[1] = '{0, 16'hFFFF, 1'b0, 1'b1, 1'b0, 28'hA01FFFF};
        tbl[2] = '{1, 16'h0000, 1'b1, 1'b1, 1'b0, 28'hB110000};
        tbl[3] = '{3, 16'hBEEF, 1'b0, 1'b0, 1'b1, 28'hD20BEEF};
        tbl[4] = '{2, 16'h8001, 1'b0, 1'b1, 1'b1, 28'hC218001};

        out_ready = 1'b0;
        s_ready   = 1'b0;
        idle();
        reset = 1'b1;
        #2 reset = 1'b0;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_record", 32'(out_record), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_drop_count", 32'(drop_count), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Single-sensor records: field packing and two-edge latency.
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(tbl[i].rec);
            set_sensor(tbl[i].sens, tbl[i].ang, tbl[i].ax, tbl[i].dt, tbl[i].lh);
            tick();
            idle();
            check($sformatf("tbl%0d_lat_edge0", i), 32'(out_valid), 32'd0);
            tick();
            check($sformatf("tbl%0d_lat_edge1", i), 32'(out_valid), 32'd1);
            check($sformatf("tbl%0d_record", i), 32'(out_record), 32'(tbl[i].rec));
            tick();
            check($sformatf("tbl%0d_consumed", i), 32'(out_valid), 32'd0);
            wait_drain($sformatf("tbl%0d", i));
        end

        // All four sensors at once: nothing lost, ids in order 0..3.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            exp_q.push_back({4'hA + 4'(i), 8'h00, 16'h0100 + 16'(i)});
            set_sensor(i, 16'h0100 + 16'(i), 1'b0, 1'b0, 1'b0);
        end
        tick();
        idle();
        wait_drain("simultaneous");
        check("simultaneous_overflow", 32'(overflow), 32'd0);
        check("simultaneous_drops", 32'(drop_count), 32'd0);

        // Back-pressure: output held by sensor 0, second strobe on sensor 1 is dropped.
        do_reset();
        out_ready = 1'b0;
        set_sensor(0, 16'h0777, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        check("bp_loaded_valid", 32'(out_valid), 32'd1);
        check("bp_loaded_record", 32'(out_record), 32'h0A000777);
        set_sensor(1, 16'h0005, 1'b0, 1'b0, 1'b0);
        tick();
        set_sensor(1, 16'h0009, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        check("bp_held_valid", 32'(out_valid), 32'd1);
        check("bp_held_record", 32'(out_record), 32'h0A000777);
        check("bp_overflow", 32'(overflow), 32'h2);
        check("bp_drop_count", 32'(drop_count), 32'd1);
        exp_q.push_back(28'hA000777);
        exp_q.push_back(28'hB000005);
        out_ready = 1'b1;
        wait_drain("bp");

        // Fairness: sensors 0 and 3 strobing every cycle alternate grants.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back((i % 2 == 0) ? 28'hA000AAA : 28'hD000333);
        end
        for (int c = 0; c < 8; c++) begin
            set_sensor(0, 16'h0AAA, 1'b0, 1'b0, 1'b0);
            set_sensor(3, 16'h0333, 1'b0, 1'b0, 1'b0);
            tick();
        end
        idle();
        wait_drain("rr");
        check("rr_overflow", 32'(overflow), 32'h9);
        check("rr_drop_count", 32'(drop_count), 32'd7);
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        check("clear_overflow", 32'(overflow), 32'd0);
        check("clear_drop_count", 32'(drop_count), 32'd0);

        // Id wrap and 2-bit saturation on the 8-sensor instance.
        do_reset();
        s_strobe[6] = 1'b1;
        s_angle[6*AB +: AB] = 16'h0042;
        tick();
        s_strobe = '0;
        tick();
        check("wrap_valid", 32'(s_valid), 32'd1);
        check("wrap_record", 32'(s_record), 32'h00000042);
        s_strobe[6] = 1'b1;
        tick();
        check("sat_no_drop_yet", 32'(s_drop), 32'd0);
        repeat (5) tick();
        s_strobe = '0;
        check("sat_drop_count", 32'(s_drop), 32'd3);
        check("sat_overflow", 32'(s_overflow), 32'h40);
        s_clear = 1'b1;
        tick();
        check("sat_clear_count", 32'(s_drop), 32'd0);
        check("sat_clear_overflow", 32'(s_overflow), 32'd0);
        s_strobe[6] = 1'b1;
        tick();
        s_strobe = '0;
        s_clear  = 1'b0;
        check("clear_with_drop_count", 32'(s_drop), 32'd1);
        check("clear_with_drop_overflow", 32'(s_overflow), 32'h40);

        // Reset mid-stream: pending work discarded, priority restarts at sensor 0.
        do_reset();
        out_ready = 1'b0;
        set_sensor(0, 16'h0010, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        set_sensor(1, 16'h0011, 1'b0, 1'b0, 1'b0);
        set_sensor(2, 16'h0012, 1'b0, 1'b0, 1'b0);
        set_sensor(3, 16'h0013, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        check("midrst_pre_valid", 32'(out_valid), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("midrst_async_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        out_ready = 1'b1;
        repeat (5) tick();
        check("midrst_quiet_valid", 32'(out_valid), 32'd0);
        check("midrst_record_zero", 32'(out_record), 32'd0);
        exp_q.push_back(28'hA000020);
        exp_q.push_back(28'hD000023);
        set_sensor(0, 16'h0020, 1'b0, 1'b0, 1'b0);
        set_sensor(3, 16'h0023, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        wait_drain("midrst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
